// File: rtl/layer_priority_compositor.sv
// Two-stage index-priority layer mux with enable mask, per-layer blinking,
// winner index and per-frame overlap flags.
module layer_priority_compositor #(
  parameter  int NUM_LAYERS   = 16,
  parameter  int RGB_W        = 8,
  parameter  int BLINK_FRAMES = 15,
  localparam int IDX_W        = (NUM_LAYERS > 2) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic [NUM_LAYERS-1:0]       layerEn,
  input  logic [NUM_LAYERS-1:0]       blinkMask,
  input  logic                        startOfFrame,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [IDX_W-1:0]            topIdx,
  output logic                        topValid,
  output logic [NUM_LAYERS-1:0]       collisions
);

  logic [7:0]                  frame_cnt;
  logic                        blink_phase;
  logic [NUM_LAYERS-1:0]       acc;

  logic [NUM_LAYERS-1:0]       phys;
  logic [NUM_LAYERS-1:0]       eff;
  logic [NUM_LAYERS-1:0]       overlap;
  logic                        multi;

  logic [NUM_LAYERS-1:0]       eff_q;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0]            bg_q;

  logic [RGB_W-1:0]            sel_rgb;
  logic [IDX_W-1:0]            sel_idx;
  logic                        sel_hit;

  assign phys = drawReq & layerEn;
  assign eff  = phys & ~(blinkMask & {NUM_LAYERS{~blink_phase}});

  // x & (x-1) is nonzero exactly when two or more bits are set
  assign multi   = |(phys & (phys - NUM_LAYERS'(1)));
  assign overlap = multi ? phys : '0;

  always_comb begin
    sel_rgb = bg_q;
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_q[i]) begin
        sel_rgb = rgb_q[i*RGB_W +: RGB_W];
        sel_idx = IDX_W'(i);
        sel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      eff_q    <= '0;
      rgb_q    <= '0;
      bg_q     <= '0;
      RGBOut   <= '0;
      topIdx   <= '0;
      topValid <= 1'b0;
    end else begin
      eff_q    <= eff;
      rgb_q    <= layerRGB;
      bg_q     <= backGroundRGB;
      RGBOut   <= sel_rgb;
      topIdx   <= sel_idx;
      topValid <= sel_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      acc         <= '0;
      collisions  <= '0;
    end else if (startOfFrame) begin
      collisions <= acc;
      acc        <= overlap;
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      acc <= acc | overlap;
    end
  end

endmodule

// File: tb/tb_layer_priority_compositor.sv
// Scoreboard bench: driver pushes model results, monitor pops one per clock.
// Reference model works from frame counts and popcounts, not register state.
module tb_layer_priority_compositor;

  localparam int NL    = 4;
  localparam int RW    = 8;
  localparam int BLINK = 2;

  typedef struct packed {
    logic [7:0] rgb;
    logic [1:0] idx;
    logic       v;
    logic [3:0] coll;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetN;
  logic [NL-1:0] drawReq;
  logic [NL*RW-1:0] layerRGB;
  logic [RW-1:0] backGroundRGB;
  logic [NL-1:0] layerEn;
  logic [NL-1:0] blinkMask;
  logic          startOfFrame;
  logic [RW-1:0] RGBOut;
  logic [1:0]    topIdx;
  logic          topValid;
  logic [NL-1:0] collisions;

  layer_priority_compositor #(
    .NUM_LAYERS(NL), .RGB_W(RW), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .resetN(resetN), .drawReq(drawReq),
    .layerRGB(layerRGB), .backGroundRGB(backGroundRGB),
    .layerEn(layerEn), .blinkMask(blinkMask),
    .startOfFrame(startOfFrame), .RGBOut(RGBOut),
    .topIdx(topIdx), .topValid(topValid),
    .collisions(collisions)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  exp_t pend = '0;
  int   sof_cnt = 0;
  logic [3:0] acc_m = '0;
  logic [3:0] coll_m = '0;
  int   vecs = 0;
  int   miscompares = 0;
  bit   running = 1'b0;

  localparam logic [31:0] COLS = 32'h44332211;

  task automatic step(input logic rst, input logic [3:0] req,
                      input logic [3:0] en, input logic [3:0] bm,
                      input logic sof, input logic [7:0] bg,
                      input logic [31:0] rgb);
    exp_t cur;
    exp_t nxt;
    logic [3:0] phys;
    logic [3:0] sel;
    logic [3:0] ov;
    bit visible;
    @(negedge clk);
    resetN = ~rst;
    drawReq = req;
    layerEn = en;
    blinkMask = bm;
    startOfFrame = sof;
    backGroundRGB = bg;
    layerRGB = rgb;
    if (rst) begin
      cur = '0;
      nxt = '0;
      sof_cnt = 0;
      acc_m = '0;
      coll_m = '0;
    end else begin
      cur = pend;
      phys = req & en;
      visible = ((sof_cnt / BLINK) % 2) == 0;
      sel = visible ? phys : (phys & ~bm);
      nxt = '0;
      nxt.rgb = bg;
      for (int i = 0; i < NL; i++) begin
        if (sel[i] && !nxt.v) begin
          nxt.v = 1'b1;
          nxt.idx = 2'(i);
          nxt.rgb = rgb[i*8 +: 8];
        end
      end
      ov = ($countones(phys) >= 2) ? phys : 4'h0;
      if (sof) begin
        coll_m = acc_m;
        acc_m = ov;
        sof_cnt++;
      end else begin
        acc_m = acc_m | ov;
      end
      cur.coll = coll_m;
    end
    pend = nxt;
    sbq.push_back(cur);
    running = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
          e = sbq.pop_front();
          vecs++;
          if ({RGBOut, topIdx, topValid, collisions} !==
              {e.rgb, e.idx, e.v, e.coll}) begin
            miscompares++;
            $display("FAIL pixel @%0t: got rgb=%h idx=%0d v=%b coll=%b, want rgb=%h idx=%0d v=%b coll=%b",
                     $time, RGBOut, topIdx, topValid, collisions,
                     e.rgb, e.idx, e.v, e.coll);
          end
        end
      end
    end
  end

  initial begin
    resetN = 1'b0;
    drawReq = '0;
    layerRGB = COLS;
    backGroundRGB = 8'hFF;
    layerEn = 4'hF;
    blinkMask = '0;
    startOfFrame = 1'b0;

    repeat (2) step(1, 4'h0, 4'hF, 4'h0, 0, 8'hFF, COLS);

    // basic priority, background, enable mask
    repeat (4) step(0, 4'b0110, 4'hF, 4'h0, 0, 8'hFF, COLS);
    repeat (3) step(0, 4'b0000, 4'hF, 4'h0, 0, 8'hFF, COLS);
    repeat (3) step(0, 4'b0110, 4'b1101, 4'h0, 0, 8'hFF, COLS);
    repeat (2) step(0, 4'b1111, 4'hF, 4'h0, 0, 8'hFF, COLS);

    // blinking layer 0 over layer 1, 4-pixel frames
    for (int f = 0; f < 6; f++)
      for (int c = 0; c < 4; c++)
        step(0, 4'b0011, 4'hF, 4'b0001, c == 0, 8'hFF, COLS);

    // single overlap pixel, then a clean frame
    step(0, 4'b0001, 4'hF, 4'h0, 1, 8'hFF, COLS);
    step(0, 4'b1010, 4'hF, 4'h0, 0, 8'hFF, COLS);
    step(0, 4'b0100, 4'hF, 4'h0, 0, 8'hFF, COLS);
    step(0, 4'b0001, 4'hF, 4'h0, 1, 8'hFF, COLS);
    repeat (3) step(0, 4'b0010, 4'hF, 4'h0, 0, 8'hFF, COLS);
    step(0, 4'b0000, 4'hF, 4'h0, 1, 8'hFF, COLS);

    // overlap on the start-of-frame pixel belongs to the new frame
    step(0, 4'b0011, 4'hF, 4'h0, 1, 8'hFF, COLS);
    repeat (3) step(0, 4'b0100, 4'hF, 4'h0, 0, 8'hFF, COLS);
    step(0, 4'b0000, 4'hF, 4'h0, 1, 8'hFF, COLS);
    repeat (2) step(0, 4'b1111, 4'hF, 4'b0001, 0, 8'hFF, COLS);

    // reset mid-stream with all layers drawing
    step(1, 4'b1111, 4'hF, 4'h0, 0, 8'hFF, COLS);
    repeat (4) step(0, 4'b1111, 4'hF, 4'b0001, 0, 8'hFF, COLS);
    step(0, 4'b0001, 4'hF, 4'b0001, 1, 8'hFF, COLS);
    step(0, 4'b0001, 4'hF, 4'b0001, 1, 8'hFF, COLS);
    repeat (2) step(0, 4'b0011, 4'hF, 4'b0001, 0, 8'hFF, COLS);

    // randomized traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) == 0,
           4'($urandom), 4'($urandom_range(0, 3) == 0 ? 15 : $urandom),
           4'($urandom), $urandom_range(0, 7) == 0,
           8'($urandom), $urandom);

    @(posedge clk);
    #2;
    running = 1'b0;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
